// File: rtl/acquire_sequencer.sv
// Scope-mode capture sequencer (stop/single/normal/auto); ACQ_SEQ_AUTO_EN builds the AUTO timeout.
// Latency: outputs registered; IDLE->trig_enable 2 cycles, reg_force->trig_immediate 1, tlast->frame_done 1.
// Backpressure: none applied; the AXI-Stream handshake is only observed.
module acquire_sequencer #(
  parameter int TIMEOUT_WIDTH     = 24,
  parameter int HOLDOFF_WIDTH     = 16,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic                         M_AXIS_ACLK,
  input  logic                         M_AXIS_ARESETN,
  input  logic [1:0]                   reg_mode,
  input  logic                         reg_arm,
  input  logic                         reg_force,
  input  logic [HOLDOFF_WIDTH-1:0]     reg_holdoff,
  input  logic [TIMEOUT_WIDTH-1:0]     reg_auto_timeout,
  input  logic                         data_in_valid,
  input  logic [1:0]                   acq_state,
  input  logic                         axis_tvalid,
  input  logic                         axis_tready,
  input  logic                         axis_tlast,
  output logic                         trig_enable,
  output logic                         trig_immediate,
  output logic [2:0]                   seq_state,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         auto_fired,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count
);

  localparam logic [1:0] MODE_STOP   = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_NORMAL = 2'b10;
  localparam logic [1:0] MODE_AUTO   = 2'b11;

  localparam logic [1:0] ACQ_ACTIVE = 2'b00;
  localparam logic [1:0] ACQ_TRIGD  = 2'b10;
  localparam logic [1:0] ACQ_STREAM = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOLDOFF   = 3'd1,
    S_ARM       = 3'd2,
    S_WAIT_TRIG = 3'd3,
    S_CAPTURE   = 3'd4,
    S_STREAM    = 3'd5,
    S_DONE      = 3'd6
  } seq_state_t;

  seq_state_t               state_q, state_d;
  logic [1:0]               mode_eff;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt_q, hold_cnt_inc;
  logic                     hold_hit;
  logic                     auto_hit;
  logic                     fired_q, fired_d;
  logic                     te_d, ti_d, af_d;

  // Compare against the count including this cycle's strobe, so the strobe that
  // reaches the target takes effect on the same edge.
  assign hold_cnt_inc = hold_cnt_q + HOLDOFF_WIDTH'(data_in_valid);
  assign hold_hit     = (reg_holdoff == '0) || (hold_cnt_inc == reg_holdoff);

`ifdef ACQ_SEQ_AUTO_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_inc;

  assign mode_eff    = reg_mode;
  assign tmo_cnt_inc = tmo_cnt_q + TIMEOUT_WIDTH'(data_in_valid);
  assign auto_hit    = (mode_eff == MODE_AUTO) && (reg_auto_timeout != '0) &&
                       (tmo_cnt_inc == reg_auto_timeout);

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) tmo_cnt_q <= '0;
    else                 tmo_cnt_q <= (state_q == S_WAIT_TRIG) ? tmo_cnt_inc : '0;
  end
`else
  logic unused_timeout;

  assign mode_eff       = (reg_mode == MODE_AUTO) ? MODE_NORMAL : reg_mode;
  assign auto_hit       = 1'b0;
  assign unused_timeout = ^reg_auto_timeout;
`endif

  always_comb begin
    state_d = state_q;
    te_d    = 1'b0;
    ti_d    = trig_immediate;
    fired_d = fired_q;
    af_d    = auto_fired;
    case (state_q)
      S_IDLE: begin
        if ((mode_eff == MODE_NORMAL) || (mode_eff == MODE_AUTO) ||
            ((mode_eff == MODE_SINGLE) && reg_arm))
          state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (mode_eff == MODE_STOP) begin
          state_d = S_IDLE;
        end else if (hold_hit) begin
          state_d = S_ARM;
          te_d    = (acq_state == ACQ_ACTIVE);
        end
      end
      // Enable pulses on the first ARM cycle with the datapath idle; the
      // following cycle moves on, so enable is only ever seen in ARM.
      S_ARM: begin
        if (mode_eff == MODE_STOP) begin
          state_d = S_IDLE;
        end else if (trig_enable) begin
          state_d = S_WAIT_TRIG;
          fired_d = 1'b0;
        end else if (acq_state == ACQ_ACTIVE) begin
          te_d = 1'b1;
        end
      end
      S_WAIT_TRIG: begin
        if ((acq_state == ACQ_TRIGD) || (acq_state == ACQ_STREAM)) begin
          state_d = (acq_state == ACQ_STREAM) ? S_STREAM : S_CAPTURE;
          ti_d    = 1'b0;
          if (!fired_q) af_d = 1'b0;
        end else if (!fired_q && (reg_force || auto_hit)) begin
          ti_d    = 1'b1;
          fired_d = 1'b1;
          af_d    = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (acq_state == ACQ_STREAM) state_d = S_STREAM;
      end
      S_STREAM: begin
        if ((axis_tvalid && axis_tready && axis_tlast) || (acq_state == ACQ_ACTIVE))
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = ((mode_eff == MODE_STOP) || (mode_eff == MODE_SINGLE)) ? S_IDLE : S_HOLDOFF;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q        <= S_IDLE;
      hold_cnt_q     <= '0;
      fired_q        <= 1'b0;
      trig_enable    <= 1'b0;
      trig_immediate <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      auto_fired     <= 1'b0;
      frame_count    <= '0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= (state_q == S_HOLDOFF) ? hold_cnt_inc : '0;
      fired_q        <= fired_d;
      trig_enable    <= te_d;
      trig_immediate <= ti_d;
      busy           <= (state_d != S_IDLE);
      frame_done     <= (state_d == S_DONE);
      auto_fired     <= af_d;
      if (state_d == S_DONE) frame_count <= frame_count + FRAME_COUNT_WIDTH'(1);
    end
  end

  assign seq_state = state_q;

endmodule

// File: tb/tb_acquire_sequencer.sv
// Self-checking bench for acquire_sequencer: drives a small datapath model, scoreboards each
// frame's expected count and trigger source, and compares them when frame_done pulses.
module tb_acquire_sequencer;
  localparam int TW = 24;
  localparam int HW = 16;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    reg_mode = 2'b00;
  logic          reg_arm = 1'b0;
  logic          reg_force = 1'b0;
  logic [HW-1:0] reg_holdoff = '0;
  logic [TW-1:0] reg_auto_timeout = '0;
  logic          data_in_valid = 1'b0;
  logic [1:0]    acq_state = 2'b00;
  logic          axis_tvalid = 1'b0;
  logic          axis_tready = 1'b0;
  logic          axis_tlast = 1'b0;
  logic          trig_enable, trig_immediate, busy, frame_done, auto_fired;
  logic [2:0]    seq_state;
  logic [FW-1:0] frame_count;

  typedef struct {
    int frames;
    bit is_auto;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_frames = 0;
  int   hold_strobes = 0;
  int   wait_strobes = 0;
  int   te_bad = 0;
  int   te_run = 0;
  bit   stop_in_wait = 1'b0;

  acquire_sequencer #(.TIMEOUT_WIDTH(TW), .HOLDOFF_WIDTH(HW), .FRAME_COUNT_WIDTH(FW)) dut (
    .M_AXIS_ACLK     (clk),
    .M_AXIS_ARESETN  (rst_n),
    .reg_mode        (reg_mode),
    .reg_arm         (reg_arm),
    .reg_force       (reg_force),
    .reg_holdoff     (reg_holdoff),
    .reg_auto_timeout(reg_auto_timeout),
    .data_in_valid   (data_in_valid),
    .acq_state       (acq_state),
    .axis_tvalid     (axis_tvalid),
    .axis_tready     (axis_tready),
    .axis_tlast      (axis_tlast),
    .trig_enable     (trig_enable),
    .trig_immediate  (trig_immediate),
    .seq_state       (seq_state),
    .busy            (busy),
    .frame_done      (frame_done),
    .auto_fired      (auto_fired),
    .frame_count     (frame_count)
  );

  always #5 clk = ~clk;

  // Strobes seen per HOLDOFF / WAIT_TRIG visit, and any enable outside a single ARM cycle.
  always @(posedge clk) begin
    if (seq_state != 3'd1) hold_strobes = 0;
    else if (data_in_valid) hold_strobes++;
    if (seq_state != 3'd3) wait_strobes = 0;
    else if (data_in_valid) wait_strobes++;
    if (trig_enable && ((acq_state == 2'b11) || (seq_state != 3'd2))) te_bad++;
    te_run = trig_enable ? te_run + 1 : 0;
    if (te_run > 1) te_bad++;
  end

  task automatic tick();
    @(negedge clk);
    data_in_valid = ($urandom_range(0, 3) != 0);
  endtask

  // Entered one cycle after trig_enable, with the sequencer in WAIT_TRIG.
  // kind: 0 edge, 1 force, 2 auto timeout, 3 AUTO mode without the timeout built.
  task automatic frame_body(input int kind);
    exp_t e;
    bit   seen;
    acq_state = 2'b01;
    if (stop_in_wait) begin
      reg_mode = 2'b00;
      tick();
      n_checks++;
      if (seq_state !== 3'd3) $display("FAIL stop_deferred: seq_state=%0d expected 3", seq_state);
      else n_pass++;
    end
    e.frames  = exp_frames + 1;
    e.is_auto = (kind == 1) || (kind == 2);
    case (kind)
      0: begin
        repeat (3) tick();
        sb.push_back(e);
        acq_state = 2'b10;
        tick();
      end
      1: begin
        tick();
        reg_force = 1'b1;
        sb.push_back(e);
        tick();
        reg_force = 1'b0;
        n_checks++;
        if (trig_immediate !== 1'b1) $display("FAIL force_to_imm: trig_immediate=%b expected 1", trig_immediate);
        else n_pass++;
        tick();
        n_checks++;
        if (trig_immediate !== 1'b1) $display("FAIL imm_hold: trig_immediate=%b expected 1", trig_immediate);
        else n_pass++;
        acq_state = 2'b10;
        tick();
        n_checks++;
        if (trig_immediate !== 1'b0) $display("FAIL imm_drop: trig_immediate=%b expected 0", trig_immediate);
        else n_pass++;
      end
      2: begin
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
          tick();
          if (trig_immediate === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || wait_strobes != int'(reg_auto_timeout))
          $display("FAIL auto_timeout: fired=%b strobes=%0d expected fired=1 strobes=%0d",
                   seen, wait_strobes, reg_auto_timeout);
        else n_pass++;
        n_checks++;
        if (auto_fired !== 1'b1) $display("FAIL auto_fired_set: auto_fired=%b expected 1", auto_fired);
        else n_pass++;
        acq_state = 2'b10;
        tick();
      end
      default: begin
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
          tick();
          if (trig_immediate !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL no_auto_build: trig_immediate rose=%b expected 0", seen);
        else n_pass++;
        sb.push_back(e);
        acq_state = 2'b10;
        tick();
      end
    endcase
    acq_state = 2'b11;
    repeat (2) tick();
    axis_tvalid = 1'b1;
    axis_tready = 1'b1;
    axis_tlast  = 1'b1;
    tick();
    axis_tvalid = 1'b0;
    axis_tready = 1'b0;
    axis_tlast  = 1'b0;
    n_checks++;
    if (frame_done !== 1'b1) $display("FAIL frame_done_latency: frame_done=%b expected 1", frame_done);
    else n_pass++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (frame_count !== FW'(e.frames)) $display("FAIL frame_count: got %0d expected %0d", frame_count, e.frames);
      else n_pass++;
      n_checks++;
      if (auto_fired !== e.is_auto) $display("FAIL auto_fired: got %b expected %b", auto_fired, e.is_auto);
      else n_pass++;
    end else begin
      n_checks++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end
    exp_frames++;
    acq_state = 2'b00;
    tick();
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL frame_done_pulse: frame_done=%b expected 0", frame_done);
    else n_pass++;
  endtask

  task automatic run_frame(input int kind, input int exp_hold);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      if (trig_enable === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL te_wait: trig_enable not seen within bound, expected a pulse");
    else n_pass++;
    if (exp_hold >= 0) begin
      n_checks++;
      if (hold_strobes != exp_hold) $display("FAIL holdoff_strobes: got %0d expected %0d", hold_strobes, exp_hold);
      else n_pass++;
    end
    tick();
    frame_body(kind);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++;
    if ({trig_enable, trig_immediate, seq_state, busy, frame_done, auto_fired, frame_count} !== '0)
      $display("FAIL reset_values: te=%b ti=%b seq=%0d busy=%b fd=%b af=%b fc=%0d expected all 0",
               trig_enable, trig_immediate, seq_state, busy, frame_done, auto_fired, frame_count);
    else n_pass++;
    rst_n   = 1'b1;
    reg_arm = 1'b1;
    tick();
    reg_arm = 1'b0;
    tick();
    n_checks++;
    if (seq_state !== 3'd0 || busy !== 1'b0)
      $display("FAIL stop_ignores_arm: seq=%0d busy=%b expected 0 0", seq_state, busy);
    else n_pass++;
  endtask

  task automatic test_single();
    reg_mode    = 2'b01;
    reg_holdoff = '0;
    repeat (2) tick();
    n_checks++;
    if (seq_state !== 3'd0) $display("FAIL single_waits_arm: seq=%0d expected 0", seq_state);
    else n_pass++;
    reg_arm = 1'b1;
    tick();
    reg_arm = 1'b0;
    n_checks++;
    if (seq_state !== 3'd1 || trig_enable !== 1'b0)
      $display("FAIL arm_cycle1: seq=%0d te=%b expected 1 0", seq_state, trig_enable);
    else n_pass++;
    tick();
    n_checks++;
    if (seq_state !== 3'd2 || trig_enable !== 1'b1)
      $display("FAIL arm_cycle2: seq=%0d te=%b expected 2 1", seq_state, trig_enable);
    else n_pass++;
    tick();
    n_checks++;
    if (seq_state !== 3'd3 || trig_enable !== 1'b0)
      $display("FAIL te_one_cycle: seq=%0d te=%b expected 3 0", seq_state, trig_enable);
    else n_pass++;
    frame_body(0);
    n_checks++;
    if (seq_state !== 3'd0 || busy !== 1'b0)
      $display("FAIL single_back_idle: seq=%0d busy=%b expected 0 0", seq_state, busy);
    else n_pass++;
  endtask

  task automatic test_normal_holdoff();
    reg_mode    = 2'b10;
    reg_holdoff = HW'(5);
    for (int f = 0; f < 3; f++) run_frame(0, 5);
    reg_mode = 2'b00;
    repeat (2) tick();
    n_checks++;
    if (seq_state !== 3'd0) $display("FAIL normal_stop: seq=%0d expected 0", seq_state);
    else n_pass++;
  endtask

  task automatic test_force_stop();
    reg_mode     = 2'b10;
    reg_holdoff  = '0;
    stop_in_wait = 1'b1;
    run_frame(1, -1);
    stop_in_wait = 1'b0;
    tick();
    n_checks++;
    if (seq_state !== 3'd0 || busy !== 1'b0)
      $display("FAIL stop_after_done: seq=%0d busy=%b expected 0 0", seq_state, busy);
    else n_pass++;
  endtask

  task automatic test_auto();
    reg_mode         = 2'b11;
    reg_holdoff      = '0;
    reg_auto_timeout = TW'(100);
`ifdef ACQ_SEQ_AUTO_EN
    run_frame(2, -1);
    run_frame(0, -1);
`else
    run_frame(3, -1);
    run_frame(1, -1);
`endif
    reg_mode = 2'b00;
    repeat (3) tick();
    n_checks++;
    if (seq_state !== 3'd0) $display("FAIL auto_stop: seq=%0d expected 0", seq_state);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    reg_mode = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (trig_enable === 1'b1) seen = 1'b1;
    end
    tick();
    acq_state = 2'b01;
    tick();
    acq_state = 2'b10;
    tick();
    acq_state = 2'b11;
    tick();
    n_checks++;
    if (!seen || seq_state !== 3'd5) $display("FAIL reach_stream: te_seen=%b seq=%0d expected 1 5", seen, seq_state);
    else n_pass++;
    #2;
    rst_n    = 1'b0;
    reg_mode = 2'b00;
    #1;
    n_checks++;
    if ({trig_enable, trig_immediate, seq_state, busy, frame_count} !== '0)
      $display("FAIL async_reset: te=%b ti=%b seq=%0d busy=%b fc=%0d expected all 0",
               trig_enable, trig_immediate, seq_state, busy, frame_count);
    else n_pass++;
    tick();
    rst_n     = 1'b1;
    acq_state = 2'b00;
    repeat (2) tick();
    n_checks++;
    if (seq_state !== 3'd0 || frame_count !== '0)
      $display("FAIL after_reset: seq=%0d fc=%0d expected 0 0", seq_state, frame_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_normal_holdoff();
    test_force_stop();
    test_auto();
    test_reset_mid();
    n_checks++;
    if (te_bad != 0) $display("FAIL te_only_in_arm: violations=%0d expected 0", te_bad);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
